// File: rtl/test_pattern_gen.sv
// Built-in ADC test pattern generator: fixed levels, checkerboard,
// toggle, PN9/PN23 pseudo-random words and ramp, one-cycle latency.
module test_pattern_gen #(
  parameter int          DATA_W    = 14,
  parameter logic [8:0]  PN9_SEED  = 9'h1FF,
  parameter logic [22:0] PN23_SEED = 23'h7FFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        select_mode,
  input  logic              reset_PN_long_gen,
  input  logic              reset_PN_short_gen,
  output logic [DATA_W-1:0] pattern_out,
  output logic              pattern_active
);

  typedef enum logic [3:0] {
    M_MID  = 4'b0001,
    M_PFS  = 4'b0010,
    M_NFS  = 4'b0011,
    M_CHK  = 4'b0100,
    M_PN23 = 4'b0101,
    M_PN9  = 4'b0110,
    M_TOG  = 4'b0111,
    M_RAMP = 4'b1111
  } mode_e;

  localparam logic [DATA_W-1:0] MID_LVL =
    {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] FS_LVL  = '1;
  localparam logic [DATA_W-1:0] CHK_EVN =
    DATA_W'({DATA_W{2'b10}});
  localparam logic [DATA_W-1:0] CHK_ODD = ~CHK_EVN;

  logic [DATA_W-1:0] pattern_q, pattern_d;
  logic              active_q, active_d;
  logic              phase_q, phase_d;
  logic [DATA_W-1:0] ramp_q, ramp_d;
  logic [8:0]        pn9_q, pn9_d;
  logic [22:0]       pn23_q, pn23_d;

  logic [DATA_W-1:0] pn9_word, pn23_word;
  logic [8:0]        pn9_adv;
  logic [22:0]       pn23_adv;

  // PN9 unroll: history bit i is s[n-9+i]; DATA_W new bits per clock
  always_comb begin
    logic [DATA_W+8:0] x9;
    x9       = '0;
    x9[8:0]  = pn9_q;
    pn9_word = '0;
    for (int j = 0; j < DATA_W; j++) begin
      x9[9+j]              = x9[4+j] ^ x9[j];
      pn9_word[DATA_W-1-j] = x9[9+j];
    end
    pn9_adv = x9[DATA_W+8 -: 9];
  end

  // PN23 unroll: history bit i is s[n-23+i]; first new bit is the MSB
  always_comb begin
    logic [DATA_W+22:0] x23;
    x23       = '0;
    x23[22:0] = pn23_q;
    pn23_word = '0;
    for (int j = 0; j < DATA_W; j++) begin
      x23[23+j]             = x23[5+j] ^ x23[j];
      pn23_word[DATA_W-1-j] = x23[23+j];
    end
    pn23_adv = x23[DATA_W+22 -: 23];
  end

  // Free-running generator state; PN resets reload without advancing
  always_comb begin
    phase_d = ~phase_q;
    ramp_d  = ramp_q + DATA_W'(1);
    pn9_d   = reset_PN_short_gen ? PN9_SEED : pn9_adv;
    pn23_d  = reset_PN_long_gen ? PN23_SEED : pn23_adv;
  end

  // Mode decode selects the word presented on the next edge
  always_comb begin
    pattern_d = '0;
    active_d  = 1'b1;
    unique case (1'b1)
      (select_mode == M_MID):  pattern_d = MID_LVL;
      (select_mode == M_PFS):  pattern_d = FS_LVL;
      (select_mode == M_NFS):  pattern_d = '0;
      (select_mode == M_CHK):
        pattern_d = phase_q ? CHK_ODD : CHK_EVN;
      (select_mode == M_PN23): pattern_d = pn23_word;
      (select_mode == M_PN9):  pattern_d = pn9_word;
      (select_mode == M_TOG):
        pattern_d = phase_q ? '0 : FS_LVL;
      (select_mode == M_RAMP): pattern_d = ramp_q;
      default: begin
        pattern_d = '0;
        active_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs, synchronous reset has priority
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= '0;
      active_q  <= 1'b0;
      phase_q   <= 1'b0;
      ramp_q    <= '0;
      pn9_q     <= PN9_SEED;
      pn23_q    <= PN23_SEED;
    end else begin
      pattern_q <= pattern_d;
      active_q  <= active_d;
      phase_q   <= phase_d;
      ramp_q    <= ramp_d;
      pn9_q     <= pn9_d;
      pn23_q    <= pn23_d;
    end
  end

  assign pattern_out    = pattern_q;
  assign pattern_active = active_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Bench for test_pattern_gen: serial-bit PN reference,
// directed checks plus randomized mode/reset traffic.
module tb_test_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  mode;
  logic        rl;
  logic        rs;
  logic [13:0] pattern_out;
  logic        pattern_active;

  int n_tests = 0;
  int n_fail  = 0;

  bit m_phase;
  int m_ramp;
  bit q9[$];
  bit q23[$];

  test_pattern_gen dut (
    .clk                (clk),
    .rst                (rst),
    .select_mode        (mode),
    .reset_PN_long_gen  (rl),
    .reset_PN_short_gen (rs),
    .pattern_out        (pattern_out),
    .pattern_active     (pattern_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic seed9();
    q9.delete();
    repeat (9) q9.push_back(1'b1);
  endtask

  task automatic seed23();
    q23.delete();
    repeat (23) q23.push_back(1'b1);
  endtask

  // s[n] = s[n-5] ^ s[n-9], 14 serial bits, first bit is MSB
  task automatic adv9(output logic [13:0] w);
    bit b;
    w = '0;
    for (int i = 0; i < 14; i++) begin
      b = q9[q9.size()-5] ^ q9[q9.size()-9];
      q9.push_back(b);
      w[13-i] = b;
    end
    while (q9.size() > 9) void'(q9.pop_front());
  endtask

  // s[n] = s[n-18] ^ s[n-23]
  task automatic adv23(output logic [13:0] w);
    bit b;
    w = '0;
    for (int i = 0; i < 14; i++) begin
      b = q23[q23.size()-18] ^ q23[q23.size()-23];
      q23.push_back(b);
      w[13-i] = b;
    end
    while (q23.size() > 23) void'(q23.pop_front());
  endtask

  // One clock: drive, predict, clock, compare
  task automatic step(input logic [3:0] m, input logic r,
                      input logic l, input logic s);
    logic [13:0] w9, w23, eo;
    logic        ea;
    mode = m;
    rst  = r;
    rl   = l;
    rs   = s;
    adv9(w9);
    adv23(w23);
    eo = '0;
    ea = 1'b0;
    if (r) begin
      m_phase = 1'b0;
      m_ramp  = 0;
      seed9();
      seed23();
    end else begin
      ea = 1'b1;
      case (m)
        4'h1: eo = 14'h2000;
        4'h2: eo = 14'h3FFF;
        4'h3: eo = 14'h0000;
        4'h4: eo = m_phase ? 14'h1555 : 14'h2AAA;
        4'h5: eo = w23;
        4'h6: eo = w9;
        4'h7: eo = m_phase ? 14'h0000 : 14'h3FFF;
        4'hF: eo = 14'(m_ramp);
        default: begin
          eo = '0;
          ea = 1'b0;
        end
      endcase
      m_phase = ~m_phase;
      m_ramp  = (m_ramp + 1) % 16384;
      if (s) seed9();
      if (l) seed23();
    end
    @(posedge clk);
    #1;
    chk($sformatf("out m=%0h", m), 32'(pattern_out), 32'(eo));
    chk($sformatf("act m=%0h", m), 32'(pattern_active), 32'(ea));
  endtask

  initial begin
    mode = 4'h0;
    rst  = 1'b1;
    rl   = 1'b0;
    rs   = 1'b0;
    m_phase = 1'b0;
    m_ramp  = 0;
    seed9();
    seed23();

    // reset, then PN9 from seed
    step(4'h6, 1'b1, 1'b0, 1'b0);
    step(4'h6, 1'b1, 1'b0, 1'b0);
    step(4'h6, 1'b0, 1'b0, 1'b0);
    chk("pn9_w0", 32'(pattern_out), 32'h01EF);
    repeat (30) step(4'h6, 1'b0, 1'b0, 1'b0);

    // PN23 reload pulse
    step(4'h5, 1'b0, 1'b1, 1'b0);
    step(4'h5, 1'b0, 1'b0, 1'b0);
    chk("pn23_w0", 32'(pattern_out), 32'h0000);
    step(4'h5, 1'b0, 1'b0, 1'b0);
    chk("pn23_w1", 32'(pattern_out), 32'h03E0);
    repeat (198) step(4'h5, 1'b0, 1'b0, 1'b0);

    // ramp full wrap
    step(4'hF, 1'b1, 1'b0, 1'b0);
    step(4'hF, 1'b0, 1'b0, 1'b0);
    chk("ramp_0", 32'(pattern_out), 32'h0000);
    for (int i = 1; i <= 16384; i++) begin
      step(4'hF, 1'b0, 1'b0, 1'b0);
      if (i == 16383)
        chk("ramp_max", 32'(pattern_out), 32'h3FFF);
      if (i == 16384)
        chk("ramp_wrap", 32'(pattern_out), 32'h0000);
    end

    // checkerboard then toggle, phase continues
    step(4'h4, 1'b1, 1'b0, 1'b0);
    step(4'h4, 1'b0, 1'b0, 1'b0);
    chk("chk_0", 32'(pattern_out), 32'h2AAA);
    step(4'h4, 1'b0, 1'b0, 1'b0);
    chk("chk_1", 32'(pattern_out), 32'h1555);
    repeat (5) step(4'h4, 1'b0, 1'b0, 1'b0);
    step(4'h7, 1'b0, 1'b0, 1'b0);
    chk("tog_sw", 32'(pattern_out), 32'h0000);
    repeat (6) step(4'h7, 1'b0, 1'b0, 1'b0);

    // sweep every code
    for (int c = 0; c < 16; c++) begin
      step(4'(c), 1'b0, 1'b0, 1'b0);
      step(4'(c), 1'b0, 1'b0, 1'b0);
    end
    step(4'h1, 1'b0, 1'b0, 1'b0);
    chk("mid", 32'(pattern_out), 32'h2000);
    step(4'h8, 1'b0, 1'b0, 1'b0);
    chk("user_act", 32'(pattern_active), 32'h0);

    // rst plus PN9 reload mid-sequence
    repeat (7) step(4'h6, 1'b0, 1'b0, 1'b0);
    step(4'h6, 1'b1, 1'b0, 1'b1);
    step(4'h6, 1'b1, 1'b0, 1'b1);
    step(4'h6, 1'b0, 1'b0, 1'b0);
    chk("pn9_rst", 32'(pattern_out), 32'h01EF);

    // held PN9 reload: word 0 follows last asserted edge
    step(4'h6, 1'b0, 1'b0, 1'b1);
    step(4'h6, 1'b0, 1'b0, 1'b1);
    step(4'h6, 1'b0, 1'b0, 1'b1);
    step(4'h6, 1'b0, 1'b0, 1'b0);
    chk("pn9_hold", 32'(pattern_out), 32'h01EF);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(4'($urandom_range(0, 15)),
           ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/test_pattern_gen.md
Name: test_pattern_gen

Overview:
- Generates the built-in ADC test patterns: fixed levels, checkerboard, one/zero toggle, PN9 short, PN23 long and ramp.
- Sits directly upstream of the test-mode output mux and is driven by the same select_mode code.
- The mux routes pattern_out onto the ADC data path whenever pattern_active is high.
- User-pattern mode (4'b1000) and normal mode are not generated here.

Parameters:
- DATA_W, 14, output word width (ADC resolution).
- PN9_SEED, 9'h1FF, PN9 LFSR reload value.
- PN23_SEED, 23'h7FFFFF, PN23 LFSR reload value.

Ports:
- clk  input  1  sample clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- select_mode  input  4  test mode code, same encoding as the test-mode mux.
- reset_PN_long_gen  input  1  synchronous reload of the PN23 LFSR to PN23_SEED.
- reset_PN_short_gen  input  1  synchronous reload of the PN9 LFSR to PN9_SEED.
- pattern_out  output  DATA_W  registered pattern word, offset binary.
- pattern_active  output  1  registered; high when the registered select_mode is a mode generated here.

Behaviour:
- Reset: synchronous, active-high, on clk only. While rst is high at a posedge:
  - pattern_out <= 0x0000, pattern_active <= 0, phase <= 0, ramp <= 0.
  - PN9 state <= PN9_SEED, PN23 state <= PN23_SEED.
  - rst takes priority over all other inputs.
- Latency: one cycle. pattern_out and pattern_active at edge N reflect select_mode and internal state sampled at edge N.
- Internal state advances every clk, independent of select_mode. Generators free-run while not selected.
- phase: 1-bit register, toggles every cycle.
- ramp: DATA_W-bit counter, +1 every cycle, wraps 0x3FFF -> 0x0000.
- PN9, serial form: s[n] = s[n-5] XOR s[n-9].
- PN23, serial form: s[n] = s[n-18] XOR s[n-23].
- Both LFSRs advance 14 serial bits per clock, computed as a parallel unroll.
- Word k = s[14k..14k+13], with pattern_out[13] = s[14k] (MSB first).
- Seed mapping: the seed holds the 9 (or 23) bits immediately preceding s[0], all ones by default.
- reset_PN_*_gen at edge E reloads the seed. The state does not advance at E. Word 0 appears on pattern_out at E+1 when that PN mode is selected, word 1 at E+2.
- A PN reset asserted for multiple cycles holds the seed; word 0 follows the last asserted edge.
- Both PN resets together reload both LFSRs. phase and ramp are unaffected by PN resets.
- Mode map (pattern_active = 1 unless stated):
  - 0001 midscale short: 0x2000.
  - 0010 +FS: 0x3FFF.
  - 0011 -FS: 0x0000.
  - 0100 checkerboard: 0x2AAA when phase = 0, 0x1555 when phase = 1.
  - 0101 PN23 long.
  - 0110 PN9 short.
  - 0111 one/zero toggle: 0x3FFF when phase = 0, 0x0000 when phase = 1.
  - 1111 ramp: current ramp value.
  - All other codes (0000, 1000, 1001-1110): pattern_out <= 0x0000, pattern_active <= 0.
- Mode change: takes effect on the next edge. No state is reset and there are no glitch or hold cycles; the new pattern continues from its free-running state.
- Reset mid-pattern: the cycle after rst deasserts, output restarts from defined values (checkerboard 0x2AAA, ramp 0x0000, PN word 0).

Test Plan:
- rst high 2 cycles, then select_mode = 0110 -> pattern_out = 0x01EF on the first edge after reset, then subsequent PN9 words; pattern_active = 1.
- select_mode = 0101, pulse reset_PN_long_gen for one cycle -> next two words 0x0000, 0x03E0. Compare 200 words against a serial PN23 reference model.
- select_mode = 1111 after reset -> 0x0000, 0x0001, 0x0002, ... Run 16385 cycles: 0x3FFF is followed by 0x0000.
- select_mode = 0100 from reset -> alternating 0x2AAA, 0x1555. Switch to 0111 mid-run -> continues in phase (0x3FFF on even phase, 0x0000 on odd), with no extra cycle.
- Sweep all 16 codes -> 0001 gives 0x2000, 0010 gives 0x3FFF, 0011 gives 0x0000. Codes 0000, 1000 and 1001-1110 give 0x0000 with pattern_active = 0. Each change is visible exactly one edge after select_mode changes.
- Assert rst and reset_PN_short_gen together while in PN9 mid-sequence -> output 0x0000 with pattern_active = 0 during rst. The first edge after release gives 0x01EF.
